countdown_timer: RTL and testbench

//  Programmable 1 Hz down-counter, the responder for the traffic-light FSM's timer_load/timer_en/timer_init interface.

---
 rtl/countdown_timer_pkg.sv | 17 +
 rtl/tick_prescaler.sv | 39 +++
 rtl/countdown_timer.sv | 66 ++++++
 tb/tb_countdown_timer.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/countdown_timer_pkg.sv
// Shared timer constants used by the countdown timer and the traffic-light FSM.
// Also provides the prescaler width helper.
package countdown_timer_pkg;

    localparam int TIMER_WIDTH    = 4;
    localparam int PRESCALE_BOARD = 100_000_000;
    localparam int PRESCALE_SIM   = 4;
    localparam int T_PED_S        = 15;
    localparam int T_GREEN_S      = 10;
    localparam int T_YELLOW_S     = 5;

    // A one-cycle prescaler still needs a 1-bit counter to stay legal.
    function automatic int prescale_width(input int prescale);
        return (prescale <= 1) ? 1 : $clog2(prescale);
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running enabled prescaler; wrap marks the last cycle of each count step.
// clr restarts the partial step, en=0 freezes it.
module tick_prescaler
    import countdown_timer_pkg::*;
#(
    parameter int PRESCALE = PRESCALE_BOARD
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic wrap
);

    localparam int            PW   = prescale_width(PRESCALE);
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign wrap = en & (cnt_q == LAST);

endmodule

// File: rtl/countdown_timer.sv
// Loadable seconds down-counter that saturates at zero, stepping once per prescaler wrap.
// tick and done are registered alongside the count so they line up with its update.
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int PRESCALE = PRESCALE_BOARD,
    parameter int WIDTH    = TIMER_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             timer_load,
    input  logic             timer_en,
    input  logic [WIDTH-1:0] timer_init,
    output logic [WIDTH-1:0] timer_out,
    output logic             tick,
    output logic             done
);

    logic             wrap;
    logic [WIDTH-1:0] count_q, count_d;
    logic             tick_q, tick_d;
    logic             done_q, done_d;

    tick_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (timer_load),
        .en   (timer_en),
        .wrap (wrap)
    );

    // Load beats a coincident wrap; at zero a step still ticks but the count holds.
    always_comb begin
        count_d = count_q;
        tick_d  = 1'b0;
        done_d  = 1'b0;
        if (timer_load) begin
            count_d = timer_init;
        end else if (wrap) begin
            tick_d = 1'b1;
            if (count_q != '0) begin
                count_d = count_q - 1'b1;
                done_d  = (count_q == WIDTH'(1));
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            tick_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            tick_q  <= tick_d;
            done_q  <= done_d;
        end
    end

    assign timer_out = count_q;
    assign tick      = tick_q;
    assign done      = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: PRESCALE=4 instance for most scenarios,
// PRESCALE=1 instance for the degenerate prescaler case.
module tb_countdown_timer;

    logic       clk;
    logic       rst;

    logic       load_a, en_a;
    logic [3:0] init_a, out_a;
    logic       tick_a, done_a;

    logic       load_b, en_b;
    logic [3:0] init_b, out_b;
    logic       tick_b, done_b;

    int vectors;
    int miscompares;

    countdown_timer #(.PRESCALE(4), .WIDTH(4)) dut_a (
        .clk        (clk),
        .rst        (rst),
        .timer_load (load_a),
        .timer_en   (en_a),
        .timer_init (init_a),
        .timer_out  (out_a),
        .tick       (tick_a),
        .done       (done_a)
    );

    countdown_timer #(.PRESCALE(1), .WIDTH(4)) dut_b (
        .clk        (clk),
        .rst        (rst),
        .timer_load (load_b),
        .timer_en   (en_b),
        .timer_init (init_b),
        .timer_out  (out_b),
        .tick       (tick_b),
        .done       (done_b)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_a(input string tag, input int exp_out, input int exp_tick, input int exp_done);
        check({tag, ".out"},  32'(out_a),  32'(exp_out));
        check({tag, ".tick"}, 32'(tick_a), 32'(exp_tick));
        check({tag, ".done"}, 32'(done_a), 32'(exp_done));
    endtask

    initial begin
        int ticks;
        int dones;
        vectors     = 0;
        miscompares = 0;
        rst    = 1'b1;
        load_a = 1'b0; en_a = 1'b0; init_a = 4'd0;
        load_b = 1'b0; en_b = 1'b0; init_b = 4'd0;
        #1;
        check_a("reset_a", 0, 0, 0);
        check("reset_b.out", 32'(out_b), 0);
        step();
        step();
        #2 rst = 1'b0;
        step();
        check_a("idle_after_reset", 0, 0, 0);

        // 1: load 5 and count down to 0, then keep ticking at 0
        load_a = 1'b1; init_a = 4'd5; en_a = 1'b1;
        step();
        load_a = 1'b0;
        check_a("t1_load", 5, 0, 0);
        for (int s = 4; s >= 0; s--) begin
            for (int c = 0; c < 3; c++) begin
                step();
                check_a("t1_wait", s + 1, 0, 0);
            end
            step();
            check_a("t1_step", s, 1, (s == 0) ? 1 : 0);
        end
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < 3; c++) step();
            check_a("t1_wait_zero", 0, 0, 0);
            step();
            check_a("t1_tick_zero", 0, 1, 0);
        end

        // 2: pause preserves count and partial second
        load_a = 1'b1; init_a = 4'd3; en_a = 1'b0;
        step();
        load_a = 1'b0;
        check_a("t2_load", 3, 0, 0);
        en_a = 1'b1;
        step();
        step();
        en_a = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            check_a("t2_paused", 3, 0, 0);
        end
        en_a = 1'b1;
        step();
        check_a("t2_resume1", 3, 0, 0);
        step();
        check_a("t2_resume2", 2, 1, 0);

        // 3: reload mid-prescale restarts the prescaler
        load_a = 1'b1; init_a = 4'd7; en_a = 1'b1;
        step();
        load_a = 1'b0;
        step();
        step();
        check_a("t3_mid", 7, 0, 0);
        load_a = 1'b1; init_a = 4'd10;
        step();
        load_a = 1'b0;
        check_a("t3_reload", 10, 0, 0);
        for (int c = 0; c < 3; c++) begin
            step();
            check_a("t3_wait", 10, 0, 0);
        end
        step();
        check_a("t3_step", 9, 1, 0);

        // 4: load 0 stays at 0 with no done, but ticks continue
        load_a = 1'b1; init_a = 4'd0; en_a = 1'b1;
        step();
        load_a = 1'b0;
        check_a("t4_load", 0, 0, 0);
        ticks = 0;
        dones = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            check("t4_out", 32'(out_a), 0);
            ticks += int'(tick_a);
            dones += int'(done_a);
        end
        check("t4_ticks", 32'(ticks), 5);
        check("t4_dones", 32'(dones), 0);

        // 5: asynchronous reset mid-count
        load_a = 1'b1; init_a = 4'd7; en_a = 1'b1;
        step();
        load_a = 1'b0;
        for (int c = 0; c < 4; c++) step();
        check_a("t5_pre_reset", 6, 1, 0);
        #2 rst = 1'b1;
        #1;
        check_a("t5_async_reset", 0, 0, 0);
        step();
        #2 rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            step();
            check("t5_idle_out", 32'(out_a), 0);
            check("t5_idle_done", 32'(done_a), 0);
        end
        en_a = 1'b0;

        // 6: PRESCALE=1 steps every enabled cycle
        load_b = 1'b1; init_b = 4'd15; en_b = 1'b1;
        step();
        load_b = 1'b0;
        check("t6_load.out", 32'(out_b), 15);
        check("t6_load.tick", 32'(tick_b), 0);
        for (int i = 1; i <= 15; i++) begin
            step();
            check("t6_step.out", 32'(out_b), 32'(15 - i));
            check("t6_step.tick", 32'(tick_b), 1);
            check("t6_step.done", 32'(done_b), (i == 15) ? 1 : 0);
        end
        step();
        check("t6_hold.out", 32'(out_b), 0);
        check("t6_hold.tick", 32'(tick_b), 1);
        check("t6_hold.done", 32'(done_b), 0);
        en_b = 1'b0;
        step();
        check("t6_pause.tick", 32'(tick_b), 0);

        // final report
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
